// File: rtl/upload_flit_serializer.sv
// Upload message serializer: captures a whole message in one handshake, then emits it one flit
// per cycle, either once (unicast) or once per set bit of the invalidation vector (multicast).
module upload_flit_serializer #(
  parameter int unsigned FLIT_W    = 16,
  parameter int unsigned NODES     = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned MAX_FLITS = 11,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          msg_valid,
  output logic                          msg_ready,
  input  logic                          msg_mode,
  input  logic [CNT_W-1:0]              msg_last_idx,
  input  logic [NODES-1:0]              msg_inv_vec,
  input  logic [MAX_FLITS*FLIT_W-1:0]   msg_flits,
  output logic [FLIT_W-1:0]             flit_out,
  output logic                          flit_valid,
  input  logic                          flit_ready,
  output logic                          flit_last,
  output logic                          busy,
  output logic                          done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [CNT_W-1:0] MaxIdx = CNT_W'(MAX_FLITS - 1);

  function automatic logic [ID_W-1:0] lowest_set(input logic [NODES-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = NODES - 1; i >= 0; i--) begin
      if (v[i]) r = ID_W'(i);
    end
    return r;
  endfunction

  logic [1:0]                         state_q, state_d;
  logic [MAX_FLITS-1:0][FLIT_W-1:0]   flits_q, flits_d;
  logic                               mode_q, mode_d;
  logic [NODES-1:0]                   mask_q, mask_d;
  logic [CNT_W-1:0]                   last_q, last_d;
  logic [CNT_W-1:0]                   sel_q, sel_d;
  logic [ID_W-1:0]                    dest_q, dest_d;

  logic                               is_last;
  logic [NODES-1:0]                   mask_rem;
  logic [FLIT_W-1:0]                  cur_flit;

  assign is_last  = (sel_q == last_q);
  assign mask_rem = mask_q & ~(NODES'(1) << dest_q);

  always_comb begin
    state_d = state_q;
    flits_d = flits_q;
    mode_d  = mode_q;
    mask_d  = mask_q;
    last_d  = last_q;
    sel_d   = sel_q;
    dest_d  = dest_q;
    case (state_q)
      StIdle: begin
        if (msg_valid) begin
          flits_d = msg_flits;
          mode_d  = msg_mode;
          mask_d  = msg_inv_vec;
          last_d  = (msg_last_idx > MaxIdx) ? MaxIdx : msg_last_idx;
          sel_d   = '0;
          dest_d  = lowest_set(msg_inv_vec);
          // An empty multicast has nothing to send but still reports completion.
          state_d = (msg_mode || (msg_inv_vec != '0)) ? StSend : StDone;
        end
      end
      StSend: begin
        if (flit_ready) begin
          if (!is_last) begin
            sel_d = sel_q + CNT_W'(1);
          end else if (mode_q) begin
            state_d = StDone;
          end else begin
            mask_d = mask_rem;
            sel_d  = '0;
            if (mask_rem != '0) dest_d = lowest_set(mask_rem);
            else                state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cur_flit = flits_q[sel_q];
    if ((sel_q == '0) && !mode_q) cur_flit[FLIT_W-1 -: ID_W] = dest_q;
    flit_out   = (state_q == StSend) ? cur_flit : '0;
    flit_valid = (state_q == StSend);
    flit_last  = (state_q == StSend) && is_last;
    msg_ready  = (state_q == StIdle);
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      flits_q <= '0;
      mode_q  <= 1'b0;
      mask_q  <= '0;
      last_q  <= '0;
      sel_q   <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      flits_q <= flits_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      dest_q  <= dest_d;
    end
  end

endmodule

// File: tb/tb_upload_flit_serializer.sv
// Bench for upload_flit_serializer: vector table driven through a flit scoreboard, plus
// backpressure and asynchronous-reset sequences.
module tb_upload_flit_serializer;
  localparam int FLIT_W    = 16;
  localparam int NODES     = 4;
  localparam int ID_W      = 2;
  localparam int MAX_FLITS = 11;
  localparam int CNT_W     = 4;

  typedef struct {
    logic                             mode;
    logic [CNT_W-1:0]                 last_idx;
    logic [NODES-1:0]                 inv_vec;
    logic [MAX_FLITS-1:0][FLIT_W-1:0] flits;
    int                               stall_at;
    int                               stall_len;
    int                               exp_flits;
  } vec_t;

  logic                          clk;
  logic                          rst;
  logic                          msg_valid;
  logic                          msg_ready;
  logic                          msg_mode;
  logic [CNT_W-1:0]              msg_last_idx;
  logic [NODES-1:0]              msg_inv_vec;
  logic [MAX_FLITS*FLIT_W-1:0]   msg_flits;
  logic [FLIT_W-1:0]             flit_out;
  logic                          flit_valid;
  logic                          flit_ready;
  logic                          flit_last;
  logic                          busy;
  logic                          done;

  upload_flit_serializer #(
    .FLIT_W   (FLIT_W),
    .NODES    (NODES),
    .ID_W     (ID_W),
    .MAX_FLITS(MAX_FLITS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .msg_valid   (msg_valid),
    .msg_ready   (msg_ready),
    .msg_mode    (msg_mode),
    .msg_last_idx(msg_last_idx),
    .msg_inv_vec (msg_inv_vec),
    .msg_flits   (msg_flits),
    .flit_out    (flit_out),
    .flit_valid  (flit_valid),
    .flit_ready  (flit_ready),
    .flit_last   (flit_last),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int            checks;
  int            errors;
  int            done_cnt;
  int            popped;
  logic [FLIT_W:0] sb[$];
  vec_t          tv[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (flit_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_flit got %0h expected no flit at %0t", flit_out, $time);
        end else begin
          check("flit", {15'd0, flit_last, flit_out}, {15'd0, sb[0]});
          if (flit_ready) begin
            void'(sb.pop_front());
            popped++;
          end
        end
      end
    end
  end

  task automatic push_expected(input vec_t v);
    int n;
    logic [FLIT_W-1:0] f;
    n = (int'(v.last_idx) > MAX_FLITS - 1) ? MAX_FLITS - 1 : int'(v.last_idx);
    for (int c = 0; c < NODES; c++) begin
      if (v.mode ? (c == 0) : v.inv_vec[c]) begin
        for (int k = 0; k <= n; k++) begin
          f = v.flits[k];
          if (k == 0 && !v.mode) f[FLIT_W-1 -: ID_W] = ID_W'(c);
          sb.push_back({(k == n), f});
        end
      end
    end
  endtask

  task automatic offer(input vec_t v);
    msg_mode     = v.mode;
    msg_last_idx = v.last_idx;
    msg_inv_vec  = v.inv_vec;
    msg_flits    = v.flits;
    msg_valid    = 1'b1;
    push_expected(v);
    @(posedge clk);
    #1;
    msg_valid    = 1'b0;
    msg_flits    = '1;
    msg_inv_vec  = '1;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int cyc;
    int stalls;
    int p0;
    int d0;
    check({name, "_msg_ready_idle"}, {31'd0, msg_ready}, 32'd1);
    p0 = popped;
    d0 = done_cnt;
    offer(v);
    check({name, "_busy"}, {31'd0, busy}, 32'd1);
    check({name, "_msg_ready_busy"}, {31'd0, msg_ready}, 32'd0);
    cyc    = 0;
    stalls = 0;
    while (done_cnt == d0 && cyc < 100) begin
      if ((popped - p0) == v.stall_at && stalls < v.stall_len) begin
        flit_ready = 1'b0;
        stalls++;
      end else begin
        flit_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    flit_ready = 1'b1;
    check({name, "_cycles"}, cyc, v.exp_flits + v.stall_len + 1);
    check({name, "_nflits"}, popped - p0, v.exp_flits);
    check({name, "_sb_empty"}, sb.size(), 0);
    check({name, "_ready_after"}, {31'd0, msg_ready}, 32'd1);
    check({name, "_idle_after"}, {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check({name, "_one_done"}, done_cnt - d0, 1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_msg_ready"}, {31'd0, msg_ready}, 32'd1);
    check({name, "_flit_valid"}, {31'd0, flit_valid}, 32'd0);
    check({name, "_flit_last"}, {31'd0, flit_last}, 32'd0);
    check({name, "_done"}, {31'd0, done}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_flit_out"}, {16'd0, flit_out}, 32'd0);
  endtask

  initial begin
    int p0;
    int wait_cyc;
    checks = 0; errors = 0; done_cnt = 0; popped = 0;
    rst = 1'b1; msg_valid = 1'b0; msg_mode = 1'b0; msg_last_idx = '0;
    msg_inv_vec = '0; msg_flits = '0; flit_ready = 1'b1;

    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < MAX_FLITS; k++) tv[i].flits[k] = 16'h1000 + 16'(k * 16'h0101);
      tv[i].stall_at  = -1;
      tv[i].stall_len = 0;
      tv[i].inv_vec   = '0;
    end
    // unicast 3 flits
    tv[0].mode = 1'b1; tv[0].last_idx = 4'd2; tv[0].exp_flits = 3;
    tv[0].flits[0] = 16'h8123; tv[0].flits[1] = 16'hA000; tv[0].flits[2] = 16'h0040;
    // multicast to nodes 0,1,3
    tv[1].mode = 1'b0; tv[1].last_idx = 4'd2; tv[1].inv_vec = 4'b1011; tv[1].exp_flits = 9;
    tv[1].flits[0] = 16'hC055; tv[1].flits[1] = 16'h1111; tv[1].flits[2] = 16'h2222;
    // unicast with 3 cycles of backpressure on flit 1
    tv[2] = tv[0]; tv[2].stall_at = 1; tv[2].stall_len = 3;
    // empty multicast
    tv[3].mode = 1'b0; tv[3].last_idx = 4'd2; tv[3].inv_vec = 4'b0000; tv[3].exp_flits = 0;
    // oversize last_idx clamps to 11 flits
    tv[4].mode = 1'b1; tv[4].last_idx = 4'hF; tv[4].exp_flits = 11;
    // head-only message
    tv[5].mode = 1'b1; tv[5].last_idx = 4'd0; tv[5].exp_flits = 1; tv[5].flits[0] = 16'h1234;
    // single-target multicast, 2 flits, dest rewritten to 2
    tv[6].mode = 1'b0; tv[6].last_idx = 4'd1; tv[6].inv_vec = 4'b0100; tv[6].exp_flits = 2;
    tv[6].flits[0] = 16'h3FFF;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("post_reset");

    for (int i = 0; i < 7; i++) run_vec(tv[i], $sformatf("vec%0d", i));

    // Async reset during the second multicast copy
    p0 = popped;
    offer(tv[1]);
    wait_cyc = 0;
    while ((popped - p0) < 4 && wait_cyc < 50) begin
      @(posedge clk);
      #1;
      wait_cyc++;
    end
    check("rst_reached_copy2", popped - p0, 4);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_vec(tv[0], "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/upload_flit_serializer.md
Name: upload_flit_serializer

Overview:
Parametrised successor to the fixed 3-flit upload datapath plus FSM pair. Captures one complete outgoing message (head + up to MAX_FLITS-1 body flits) in a single handshake. Serialises it one flit per cycle into the upload request FIFO. Two modes: unicast, with destination taken from the head flit; invalidation multicast, which emits one full copy per set bit of an invalidation vector with the head destination field rewritten. The FSM, counters and flit mux are integrated in one block.

Parameters:
FLIT_W, 16, flit width in bits
NODES, 4, ring node count; width of the invalidation vector
ID_W, 2, destination-id field width; occupies head[FLIT_W-1 -: ID_W]; requires NODES <= 2**ID_W
MAX_FLITS, 11, flit registers per message (head + 10 body)
CNT_W, 4, flit-index counter width; requires 2**CNT_W >= MAX_FLITS

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
msg_valid  in  1  message offered
msg_ready  out  1  block can accept a message
msg_mode  in  1  0 = invalidation multicast, 1 = unicast (wb/flush/sc)
msg_last_idx  in  CNT_W  index of the last flit (flit count - 1)
msg_inv_vec  in  NODES  multicast targets; bit i = node i
msg_flits  in  MAX_FLITS*FLIT_W  flit k at bits [k*FLIT_W +: FLIT_W]; flit 0 = head
flit_out  out  FLIT_W  flit to request FIFO
flit_valid  out  1  flit_out valid
flit_ready  in  1  FIFO not full
flit_last  out  1  flit_out is the last flit of the current copy
busy  out  1  state != IDLE
done  out  1  one-cycle pulse: message fully sent or dropped

Behaviour:
- Reset (async, any state): state=IDLE, all capture regs, counters and mask = 0. Outputs: msg_ready=1, flit_valid=0, flit_last=0, done=0, busy=0, flit_out=0.
- States: IDLE, SEND, DONE.
- IDLE: msg_ready=1. Accept when msg_valid. Capture flits, mode, inv_vec as the pending mask, and last_idx. If msg_last_idx > MAX_FLITS-1, clamp to MAX_FLITS-1. Clear sel_cnt.
  - Unicast -> SEND.
  - Multicast with nonzero vector -> SEND; dest = lowest set bit of the mask.
  - Multicast with vector 0 -> DONE; no flits emitted.
- SEND: flit_valid=1; flit_out = flit[sel_cnt].
  - When sel_cnt==0, head dest field = captured head dest (unicast) or current dest id (multicast). Other head bits are unchanged.
  - flit_last = (sel_cnt==last_idx).
  - Transfer occurs when flit_valid && flit_ready. Without a transfer, flit_out, flit_last and all state hold (no change under backpressure).
  - On transfer with !flit_last: sel_cnt+1.
  - On transfer with flit_last:
    - Unicast -> DONE.
    - Multicast: clear the current dest bit in the mask. If the remaining mask is nonzero, sel_cnt=0, dest = next lowest set bit, stay in SEND (next copy's head on the following cycle, no bubble). Otherwise -> DONE.
- DONE: done=1 for exactly one cycle, then IDLE. msg_ready=0 in DONE.
- Latency: head flit valid on the cycle after acceptance. Throughput: 1 flit/cycle with flit_ready held high.
- Multicast copies go in ascending node order. Copies count = popcount(inv_vec).
- msg_last_idx=0: single-flit message; the head is also flit_last.
- Inputs are ignored outside IDLE; no message is accepted in SEND/DONE.
- Counter wrap is impossible by construction (clamp). Dest id zero-extended to ID_W.

Test Plan:
- Unicast, last_idx=2, head=16'h8123, addr flits 16'hA000/16'h0040, flit_ready=1 -> flit_out 8123, A000, 0040 on 3 consecutive cycles; flit_last on the 3rd; done 1 cycle later; msg_ready back high.
- Multicast, inv_vec=4'b1011, head=16'hC055, last_idx=2 -> 9 flits. Heads 0055, 4055, C055 (dests 0,1,3) with body flits repeated; node 2 skipped; single done pulse.
- Backpressure: unicast 3 flits, flit_ready low for 3 cycles at sel_cnt=1 -> flit_out holds flit 1 with flit_valid=1; no flit lost or duplicated; completion delayed by 3 cycles.
- Multicast with inv_vec=0 -> no flit_valid; done pulse on the cycle after acceptance.
- last_idx=4'hF (MAX_FLITS=11) -> exactly 11 flits emitted; flit_last on flit 10. last_idx=0 -> head only, flit_last=1.
- Assert rst mid-SEND of the 2nd multicast copy -> outputs go to reset values immediately (async). Next accepted message is serialised correctly from its head.
